// File: rtl/mod7_sched.sv
// Round-robin scheduler in front of a shared bit-serial mod-7 residue engine.
// Each granted word is shifted MSB-first; the residue is returned with the requester ID.
module mod7_sched #(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [2:0]            res_data,
  output logic [IDW-1:0]        res_id,
  output logic                  busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       residue, residue_nxt;
  logic [3:0]       dbl;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [IDW-1:0]   ptr;
  logic             found, found_hi, found_lo;
  logic [IDW-1:0]   winner, win_hi, win_lo;
  logic [WIDTH-1:0] win_word;
  logic             accept;

  // Two-pass search: indices above the pointer first, then wrap to 0..pointer.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found_hi && req_valid[i] && (32'(ptr) < i)) begin
        found_hi = 1'b1;
        win_hi   = IDW'(i);
      end
      if (!found_lo && req_valid[i] && (i <= 32'(ptr))) begin
        found_lo = 1'b1;
        win_lo   = IDW'(i);
      end
    end
    found  = found_hi | found_lo;
    winner = found_hi ? win_hi : win_lo;
  end

  always_comb begin
    win_word = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) win_word = req_data[i*WIDTH +: WIDTH];
    end
  end

  assign accept = (state == IDLE) && found && !rst;

  // 2*r + bit stays below 14, so one conditional subtract keeps it in 0..6.
  assign dbl         = {residue, shreg[WIDTH-1]};
  assign residue_nxt = (dbl >= 4'd7) ? 3'(dbl - 4'd7) : dbl[2:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    res_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (accept) begin
          for (int unsigned i = 0; i < NREQ; i++) req_ready[i] = (winner == IDW'(i));
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The pointer doubles as the ID of the word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      residue  <= '0;
      cnt      <= '0;
      shreg    <= '0;
      ptr      <= IDW'(NREQ - 1);
      res_data <= '0;
      res_id   <= '0;
    end else if (accept) begin
      shreg   <= win_word;
      residue <= '0;
      cnt     <= CW'(WIDTH);
      ptr     <= winner;
    end else if (state == SHIFT) begin
      residue <= residue_nxt;
      shreg   <= shreg << 1;
      cnt     <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        res_data <= residue_nxt;
        res_id   <= ptr;
      end
    end
  end

endmodule
